// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared op and controller state encodings for the data RAM path
package data_mem_pkg;
  typedef enum logic [1:0] {
    OP_LOAD    = 2'b00,
    OP_STORE   = 2'b01,
    OP_COPY    = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_t;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_CAP, WR, RESP} state_t;
endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: core-side command/response bus (cmd_* valid/ready in, rsp_* pulse and busy out)
interface data_mem_ctrl_if #(parameter int DWIDTH = 16, parameter int ADDR_WIDTH = 16, parameter int LEN_WIDTH = 8);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] cmd_dst;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [DWIDTH-1:0]     cmd_wdata;
  logic                  rsp_valid;
  logic [DWIDTH-1:0]     rsp_data;
  logic                  rsp_err;
  logic                  busy;
  modport master (output cmd_valid, cmd_op, cmd_addr, cmd_dst, cmd_len, cmd_wdata,
                  input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy);
  modport slave  (input  cmd_valid, cmd_op, cmd_addr, cmd_dst, cmd_len, cmd_wdata,
                  output cmd_ready, rsp_valid, rsp_data, rsp_err, busy);
endinterface

// File: rtl/data_mem_ctrl_copy_counter.sv
// copy_counter: holds copy len and src/dst bases; gives src+i, dst+i (wrapping) and a last-word flag
module copy_counter #(parameter int ADDR_WIDTH = 16, parameter int LEN_WIDTH = 8) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  inc,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  output logic [ADDR_WIDTH-1:0] src_addr,
  output logic [ADDR_WIDTH-1:0] dst_addr,
  output logic                  last
);
  logic [LEN_WIDTH-1:0]  i, len_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      i     <= '0;
      len_q <= '0;
      src_q <= '0;
      dst_q <= '0;
    end else if (load) begin
      i     <= '0;
      len_q <= len;
      src_q <= src;
      dst_q <= dst;
    end else if (inc) begin
      i <= i + 1'b1;
    end
  end
  assign src_addr = src_q + ADDR_WIDTH'(i);
  assign dst_addr = dst_q + ADDR_WIDTH'(i);
  assign last     = i + LEN_WIDTH'(1) == len_q;
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: sequences data RAM pins for load/store/copy commands from bus, one-cycle response pulse per command
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DWIDTH     = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_ctrl_if.slave        bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0]     ram_data,
  output logic                  ram_we,
  input  logic [DWIDTH-1:0]     ram_dout
);
  state_t                state, state_n;
  op_t                   op_q;
  logic                  accept, last;
  logic [ADDR_WIDTH-1:0] src_addr, dst_addr;
  logic [DWIDTH-1:0]     rsp_data_q;
  assign bus.cmd_ready = state == IDLE && !rst;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign bus.busy      = state != IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_err   = state == RESP && op_q == OP_ILLEGAL;
  assign bus.rsp_data  = rsp_data_q;
  assign ram_we        = state == WR && !rst;
  copy_counter #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) u_cnt (
    .clk(clk), .rst(rst), .load(accept), .inc(state == WR && op_q == OP_COPY),
    .len(bus.cmd_len), .src(bus.cmd_addr), .dst(bus.cmd_dst),
    .src_addr(src_addr), .dst_addr(dst_addr), .last(last)
  );
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = !accept ? IDLE :
                         bus.cmd_op == OP_LOAD ? RD_ADDR :
                         bus.cmd_op == OP_STORE ? WR :
                         (bus.cmd_op == OP_COPY && |bus.cmd_len) ? RD_ADDR : RESP;
      RD_ADDR: state_n = RD_CAP;
      RD_CAP:  state_n = op_q == OP_LOAD ? RESP : WR;
      WR:      state_n = (op_q == OP_COPY && !last) ? RD_ADDR : RESP;
      default: state_n = IDLE;
    endcase
  end
  // ram_data doubles as the copy word buffer between RD_CAP and WR
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_LOAD;
      rsp_data_q <= '0;
      ram_addr   <= '0;
      ram_data   <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q       <= op_t'(bus.cmd_op);
        rsp_data_q <= bus.cmd_op == OP_COPY ? DWIDTH'(bus.cmd_len) : '0;
        if (state_n != RESP) ram_addr <= bus.cmd_addr;
        if (bus.cmd_op == OP_STORE) ram_data <= bus.cmd_wdata;
      end
      if (state == RD_CAP && op_q == OP_LOAD) rsp_data_q <= ram_dout;
      if (state == RD_CAP && op_q != OP_LOAD) begin
        ram_addr <= dst_addr;
        ram_data <= ram_dout;
      end
      if (state == WR && state_n == RD_ADDR) ram_addr <= src_addr + 1'b1;
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed and random load/store/copy traffic against a word-array reference model
module tb_data_mem_ctrl;
  import data_mem_pkg::*;
  logic        clk = 0;
  logic        rst = 1;
  logic [15:0] ram_addr, ram_data, ram_dout, raddr;
  logic        ram_we;
  logic [15:0] ram     [0:65535];
  logic [15:0] ref_mem [0:65535];
  int total = 0;
  int bad = 0;
  data_mem_ctrl_if #(.DWIDTH(16), .ADDR_WIDTH(16), .LEN_WIDTH(8)) bus ();
  data_mem_ctrl #(.DWIDTH(16), .ADDR_WIDTH(16), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_dout(ram_dout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_data;
    else raddr <= ram_addr;
  end
  assign ram_dout = ram_we ? 16'h0 : ram[raddr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic scramble();
    bus.cmd_op    = 2'($urandom);
    bus.cmd_addr  = 16'($urandom);
    bus.cmd_dst   = 16'($urandom);
    bus.cmd_len   = 8'($urandom);
    bus.cmd_wdata = 16'($urandom);
  endtask
  // Called just after a negedge with the controller idle; returns just after a negedge, idle again.
  task automatic run_cmd(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                         input logic [7:0] len, input logic [15:0] wd);
    logic [15:0] exp_data, s, t;
    int exp_lat, exp_we, n, lat, wes;
    bit busy_ok;
    exp_data = 0;
    exp_lat  = 1;
    exp_we   = 0;
    if (op == OP_LOAD) begin
      exp_data = ref_mem[a];
      exp_lat  = 3;
    end else if (op == OP_STORE) begin
      exp_lat    = 2;
      exp_we     = 1;
      ref_mem[a] = wd;
    end else if (op == OP_COPY) begin
      exp_data = 16'(len);
      exp_lat  = len == 0 ? 1 : 3 * int'(len) + 1;
      exp_we   = int'(len);
      for (int i = 0; i < int'(len); i++) begin
        s = a + 16'(i);
        t = d + 16'(i);
        ref_mem[t] = ref_mem[s];
      end
    end
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_dst   = d;
    bus.cmd_len   = len;
    bus.cmd_wdata = wd;
    bus.cmd_valid = 1;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", n, 0);
    @(negedge clk);
    bus.cmd_valid = 0;
    scramble();
    lat = 0;
    wes = 0;
    busy_ok = 1;
    for (int k = 1; k <= 800; k++) begin
      if (ram_we) wes++;
      if (!bus.busy) busy_ok = 0;
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    chk("latency", lat, exp_lat);
    chk("rsp_data", bus.rsp_data, exp_data);
    chk("rsp_err", bus.rsp_err, op == OP_ILLEGAL);
    chk("we_cycles", wes, exp_we);
    chk("busy_held", busy_ok, 1);
    @(negedge clk);
    chk("rsp_one_cycle", bus.rsp_valid, 0);
    chk("ready_after", bus.cmd_ready, 1);
    chk("busy_after", bus.busy, 0);
  endtask
  initial begin
    logic [1:0]  b_op [8];
    logic [15:0] b_a  [8];
    logic [15:0] b_d  [8];
    logic [15:0] expq [$];
    int idx, got;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 0;
    bus.cmd_valid = 0;
    scramble();
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.cmd_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data", ram_data, 0);
    rst = 0;
    #1;
    chk("ready_out_of_rst", bus.cmd_ready, 1);
    for (int i = 0; i < 64; i++) run_cmd(OP_STORE, 16'(i), 0, 0, 0);
    for (int i = 0; i < 16; i++) run_cmd(OP_STORE, 16'hFFF0 + 16'(i), 0, 0, 0);
    run_cmd(OP_STORE, 16'h0010, 0, 0, 16'hBEEF);
    run_cmd(OP_LOAD, 16'h0010, 0, 0, 0);
    for (int i = 0; i < 4; i++) run_cmd(OP_STORE, 16'h0100 + 16'(i), 0, 0, 16'(i + 1));
    run_cmd(OP_COPY, 16'h0100, 16'h0200, 4, 0);
    for (int i = 0; i < 4; i++) run_cmd(OP_LOAD, 16'h0200 + 16'(i), 0, 0, 0);
    run_cmd(OP_STORE, 16'hFFFE, 0, 0, 7);
    run_cmd(OP_STORE, 16'hFFFF, 0, 0, 8);
    run_cmd(OP_STORE, 16'h0000, 0, 0, 9);
    run_cmd(OP_COPY, 16'hFFFE, 16'h0000, 3, 0);
    for (int i = 0; i < 3; i++) run_cmd(OP_LOAD, 16'(i), 0, 0, 0);
    run_cmd(OP_COPY, 16'h0005, 16'h0006, 0, 0);
    run_cmd(OP_ILLEGAL, 16'h0005, 16'h0006, 3, 16'h1234);
    for (int i = 0; i < 4; i++) begin
      run_cmd(OP_STORE, 16'h0300 + 16'(i), 0, 0, 16'(11 + i));
      run_cmd(OP_STORE, 16'h0310 + 16'(i), 0, 0, 0);
    end
    bus.cmd_op    = OP_COPY;
    bus.cmd_addr  = 16'h0300;
    bus.cmd_dst   = 16'h0310;
    bus.cmd_len   = 4;
    bus.cmd_valid = 1;
    chk("abort_accept", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 0;
    repeat (5) @(negedge clk);
    chk("abort_in_wr", ram_we, 1);
    rst = 1;
    #1;
    chk("abort_we_gated", ram_we, 0);
    chk("abort_no_rsp", bus.rsp_valid, 0);
    ref_mem[16'h0310] = ref_mem[16'h0300];
    @(negedge clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_rsp_data", bus.rsp_data, 0);
    chk("abort_addr", ram_addr, 0);
    chk("abort_data", ram_data, 0);
    chk("abort_we", ram_we, 0);
    chk("abort_ready_in_rst", bus.cmd_ready, 0);
    rst = 0;
    #1;
    run_cmd(OP_LOAD, 16'h0310, 0, 0, 0);
    run_cmd(OP_LOAD, 16'h0311, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      b_op[k] = k % 2 == 1 ? OP_LOAD : OP_STORE;
      b_a[k]  = 16'h0040 + 16'(k / 2);
      b_d[k]  = 16'($urandom);
    end
    idx = 0;
    got = 0;
    for (int c = 0; c < 400 && (idx < 8 || got < 8); c++) begin
      if (bus.rsp_valid) begin
        if (expq.size() == 0) chk("b2b_unexpected_rsp", bus.rsp_valid, 0);
        else chk("b2b_data", bus.rsp_data, expq.pop_front());
        got++;
      end
      if (idx < 8) begin
        bus.cmd_op    = b_op[idx];
        bus.cmd_addr  = b_a[idx];
        bus.cmd_wdata = b_d[idx];
        bus.cmd_valid = 1;
        if (bus.cmd_ready) begin
          if (b_op[idx] == OP_STORE) begin
            ref_mem[b_a[idx]] = b_d[idx];
            expq.push_back(0);
          end else expq.push_back(ref_mem[b_a[idx]]);
          idx++;
        end
      end else bus.cmd_valid = 0;
      @(negedge clk);
    end
    bus.cmd_valid = 0;
    chk("b2b_accepted", idx, 8);
    chk("b2b_responses", got, 8);
    repeat (2) @(negedge clk);
    for (int r = 0; r < 60; r++) begin
      logic [15:0] a, d;
      a = 16'($urandom_range(0, 31)) + ($urandom_range(0, 3) == 0 ? 16'hFFF0 : 16'h0);
      d = 16'($urandom_range(0, 31)) + ($urandom_range(0, 3) == 0 ? 16'hFFF0 : 16'h0);
      run_cmd(2'($urandom_range(0, 3)), a, d, 8'($urandom_range(0, 6)), 16'($urandom));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
